// File: rtl/bus_dma.sv
// Byte-copy DMA engine that borrows the system bus while the CPU is halted.
// Each byte is moved in three bus cycles: address, read latency, then write.
module bus_dma (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        reg_cs,
    input  logic [2:0]  reg_addr,
    input  logic        reg_we,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] addr_o,
    output logic        R_W_n,
    output logic [7:0]  data_o,
    input  logic [7:0]  data_i,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_LAT,
        S_WR
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [15:0] len_q;
    logic [15:0] len_dec;
    logic [7:0]  latch_q;
    logic        irq_en_q;
    logic        src_fix_q;
    logic        dst_fix_q;
    logic        done_q;
    logic        reg_wr;
    logic        cfg_wr;
    logic        start;
    logic        len_zero;
    logic        done_set;
    logic        done_clr;

    assign busy     = (state_q != S_IDLE);
    assign irq      = done_q & irq_en_q;
    assign len_zero = (len_q == 16'h0000);
    assign len_dec  = len_q - 16'h0001;
    assign reg_wr   = reg_cs & reg_we;
    // Configuration is frozen while a transfer owns the working registers.
    assign cfg_wr   = reg_wr & ~busy;
    assign start    = cfg_wr & (reg_addr == 3'd6) & reg_wdata[0];

    assign done_set = (start & len_zero)
                    | ((state_q == S_WR) & (len_dec == 16'h0000));
    assign done_clr = (reg_wr & (reg_addr == 3'd7) & reg_wdata[1])
                    | (start & ~len_zero);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bus_req = 1'b1;
        addr_o  = 16'h0000;
        R_W_n   = 1'b1;
        data_o  = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                bus_req = 1'b0;
                if (start && !len_zero) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus_gnt) state_d = S_RD;
            end
            S_RD: begin
                addr_o  = src_q;
                state_d = bus_gnt ? S_LAT : S_REQ;
            end
            S_LAT: begin
                addr_o  = src_q;
                state_d = bus_gnt ? S_WR : S_REQ;
            end
            S_WR: begin
                addr_o  = dst_q;
                R_W_n   = 1'b0;
                data_o  = latch_q;
                state_d = (len_dec == 16'h0000) ? S_IDLE : S_RD;
            end
            default: begin
                bus_req = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            src_q     <= 16'h0000;
            dst_q     <= 16'h0000;
            len_q     <= 16'h0000;
            latch_q   <= 8'h00;
            irq_en_q  <= 1'b0;
            src_fix_q <= 1'b0;
            dst_fix_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (cfg_wr) begin
                case (reg_addr)
                    3'd0: src_q[7:0]  <= reg_wdata;
                    3'd1: src_q[15:8] <= reg_wdata;
                    3'd2: dst_q[7:0]  <= reg_wdata;
                    3'd3: dst_q[15:8] <= reg_wdata;
                    3'd4: len_q[7:0]  <= reg_wdata;
                    3'd5: len_q[15:8] <= reg_wdata;
                    3'd6: {dst_fix_q, src_fix_q, irq_en_q} <= reg_wdata[3:1];
                    default: ;
                endcase
            end
            if ((state_q == S_LAT) && bus_gnt) latch_q <= data_i;
            if (state_q == S_WR) begin
                len_q <= len_dec;
                if (!src_fix_q) src_q <= src_q + 16'h0001;
                if (!dst_fix_q) dst_q <= dst_q + 16'h0001;
            end
            // Completion beats a simultaneous software clear.
            if (done_set) done_q <= 1'b1;
            else if (done_clr) done_q <= 1'b0;
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            3'd0: reg_rdata = src_q[7:0];
            3'd1: reg_rdata = src_q[15:8];
            3'd2: reg_rdata = dst_q[7:0];
            3'd3: reg_rdata = dst_q[15:8];
            3'd4: reg_rdata = len_q[7:0];
            3'd5: reg_rdata = len_q[15:8];
            3'd6: reg_rdata = {4'b0000, dst_fix_q, src_fix_q, irq_en_q, 1'b0};
            3'd7: reg_rdata = {6'b000000, done_q, busy};
            default: reg_rdata = 8'h00;
        endcase
    end

endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk_i  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n_i  in  1  reset, synchronous, active-low.
REQ-004 reg_cs  in  1  register-file select from address decoder (DMA IO page).
REQ-005 reg_addr  in  3  register index.
REQ-006 reg_we  in  1  register write strobe, qualified by reg_cs.
REQ-007 reg_wdata  in  8  register write data.
REQ-008 reg_rdata  out  8  register read data, combinational from reg_addr.
REQ-009 bus_req  out  1  request for system bus ownership (CPU halt).
REQ-010 bus_gnt  in  1  bus granted; CPU halted while high.
REQ-011 addr_o  out  16  bus address driven while owning the bus.
REQ-012 R_W_n  out  1  bus direction, 1 = read, 0 = write.
REQ-013 data_o  out  8  bus write data.
REQ-014 data_i  in  8  bus read data, valid one cycle after address.
REQ-015 busy  out  1  transfer in progress.
REQ-016 irq  out  1  level interrupt: done AND irq enable.

Function
REQ-017 Register map SHALL be: 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H, 6 CTRL, 7 STATUS.
REQ-018 CTRL SHALL be: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN, bit2 SRC_FIX, bit3 DST_FIX; bits 7:4 read 0.
REQ-019 STATUS SHALL read {6'b0, done, busy}; writing 1 to bit1 clears done.
REQ-020 Writes to registers 0-6 while busy SHALL be ignored; STATUS clear SHALL always be accepted.
REQ-021 SRC/DST/LEN reads SHALL return live working values, which update during a transfer.
REQ-022 States SHALL be IDLE, REQ, RD, LAT, WR.
REQ-023 IDLE: START with LEN!=0 -> REQ, busy=1, done cleared; START with LEN==0 -> stays IDLE, done=1, no bus request.
REQ-024 REQ: bus_req=1; bus_gnt=1 -> RD.
REQ-025 RD: addr_o=SRC, R_W_n=1 for one cycle -> LAT.
REQ-026 LAT: addr_o=SRC, R_W_n=1; data_i captured into byte latch at end of cycle -> WR.
REQ-027 WR: addr_o=DST, R_W_n=0, data_o=latch for one cycle; then LEN-=1, SRC+=1 unless SRC_FIX, DST+=1 unless DST_FIX.
REQ-028 After WR: new LEN!=0 -> RD; new LEN==0 -> IDLE, bus_req=0, busy=0, done=1 in the same edge.
REQ-029 Throughput SHALL be 3 cycles per byte; first RD cycle SHALL be the cycle after bus_gnt is seen high in REQ.
REQ-030 Address increments SHALL wrap 16'hFFFF -> 16'h0000 with no flag.
REQ-031 bus_req SHALL be 1 in REQ, RD, LAT, WR and 0 in IDLE.
REQ-032 bus_gnt low in RD or LAT SHALL abort the current byte (no write, no counter update) -> REQ; byte restarts at RD on regrant.
REQ-033 bus_gnt low during WR SHALL be ignored; the write completes.
REQ-034 Outside RD/LAT/WR: addr_o=16'h0000, R_W_n=1, data_o=8'h00.
REQ-035 A STATUS done-clear write in the same cycle done is set SHALL lose; done ends set.
REQ-036 reg_cs with reg_we=0 SHALL have no side effects.

Reset
REQ-037 With rst_n_i low at a clock edge, state SHALL go to IDLE and SRC, DST, LEN, CTRL, latch SHALL reset to 0; done=0, busy=0, bus_req=0, irq=0, R_W_n=1, addr_o=0, data_o=0.
REQ-038 Reset mid-transfer SHALL abandon the transfer at once with no further bus write.

Verification
REQ-039 SRC=0x1000, DST=0x2000, LEN=3, START; grant immediately -> 3 reads/3 writes of 0x1000-2 to 0x2000-2, 9 bus cycles, done=1, LEN reads 0.
REQ-040 LEN=0, START -> bus_req never asserted, STATUS=0x02 next cycle; IRQ_EN=1 -> irq=1; write STATUS=0x02 -> irq=0.
REQ-041 SRC=0xFFFF, DST=0x0100, LEN=2 -> reads 0xFFFF then 0x0000; SRC ends 0x0001.
REQ-042 SRC_FIX=1, SRC=0xFE00, DST=0x3000, LEN=4 -> four reads of 0xFE00, writes to 0x3000-3; SRC stays 0xFE00.
REQ-043 Drop bus_gnt during LAT of byte 2 for 5 cycles -> no write for byte 2 until regrant; byte 2 reread from same SRC, final memory correct.
REQ-044 Write SRC_L=0x55 while busy -> ignored; reset asserted during WR of byte 1 of LEN=4 -> next cycle IDLE, all outputs at reset values, no further writes.
